// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
//   Shared AXI definitions for the write-burst master: controller state
//   encoding, AXI burst-type codes and AXI response codes.
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/axi_wr_burst_master.sv
// ---------------------------------------------------------------------------
// axi_wr_burst_master
//   Issues one AXI write burst at a time: accepts a command (address, beats
//   minus one, ID), drives the AW channel, streams the beats from the IN_*
//   interface onto W (combinational pass-through), then waits for the B
//   response and reports it with a one-cycle DONE_VALID pulse.
//
// Ports
//   MASTER_CLK, MASTER_RSTN       clock, synchronous active-low reset
//   CMD_*                         burst command (valid/ready, addr, len, id)
//   IN_*                          write beat source (data, strb, valid/ready)
//   DONE_VALID, DONE_RESP         completion pulse and response
//   MASTER_WR_ADDR_*              AXI AW channel
//   MASTER_WR_DATA_*, _STRB       AXI W channel
//   MASTER_WR_BACK_*              AXI B channel
//
// Configuration
//   AXI_WR_TIMEOUT_EN  when defined, a B response not received within
//                      TIMEOUT_CYC cycles of entering RESP completes the
//                      burst with DONE_RESP = DECERR (2'b11).
// ---------------------------------------------------------------------------
module axi_wr_burst_master
    import axi_pkg::*;
#(
    parameter logic [1:0]  BURST_TYPE  = 2'b01,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        MASTER_CLK,
    input  logic        MASTER_RSTN,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_ADDR,
    input  logic [7:0]  CMD_LEN,
    input  logic [3:0]  CMD_ID,
    input  logic [31:0] IN_DATA,
    input  logic [3:0]  IN_STRB,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic        DONE_VALID,
    output logic [1:0]  DONE_RESP,
    output logic [3:0]  MASTER_WR_ADDR_ID,
    output logic [31:0] MASTER_WR_ADDR,
    output logic [7:0]  MASTER_WR_ADDR_LEN,
    output logic [1:0]  MASTER_WR_ADDR_BURST,
    output logic        MASTER_WR_ADDR_VALID,
    input  logic        MASTER_WR_ADDR_READY,
    output logic [31:0] MASTER_WR_DATA,
    output logic [3:0]  MASTER_WR_STRB,
    output logic        MASTER_WR_DATA_LAST,
    output logic        MASTER_WR_DATA_VALID,
    input  logic        MASTER_WR_DATA_READY,
    input  logic [3:0]  MASTER_WR_BACK_ID,
    input  logic [1:0]  MASTER_WR_BACK_RESP,
    input  logic        MASTER_WR_BACK_VALID,
    output logic        MASTER_WR_BACK_READY
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    wr_state_t   state, state_nxt;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [3:0]  id_q;
    logic [8:0]  beat_cnt;   // 9 bits so len=255 counts 256 beats
    logic        last_beat;
    logic        w_hs;

    assign last_beat = (beat_cnt == {1'b0, len_q});
    assign w_hs      = (state == DATA) && IN_VALID && MASTER_WR_DATA_READY;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC));

    // Cycles spent in RESP; cleared everywhere else.
    always_ff @(posedge MASTER_CLK) begin
        if (!MASTER_RSTN || state != RESP) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge MASTER_CLK) begin
        if (!MASTER_RSTN) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && CMD_VALID) begin
                addr_q   <= CMD_ADDR;
                len_q    <= CMD_LEN;
                id_q     <= CMD_ID;
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

    always_comb begin
        state_nxt            = state;
        CMD_READY            = 1'b0;
        IN_READY             = 1'b0;
        DONE_VALID           = 1'b0;
        DONE_RESP            = '0;
        MASTER_WR_ADDR_ID    = '0;
        MASTER_WR_ADDR       = '0;
        MASTER_WR_ADDR_LEN   = '0;
        MASTER_WR_ADDR_BURST = '0;
        MASTER_WR_ADDR_VALID = 1'b0;
        MASTER_WR_DATA       = '0;
        MASTER_WR_STRB       = '0;
        MASTER_WR_DATA_LAST  = 1'b0;
        MASTER_WR_DATA_VALID = 1'b0;
        MASTER_WR_BACK_READY = 1'b0;

        unique case (state)
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) state_nxt = ADDR;
            end
            ADDR: begin
                MASTER_WR_ADDR_VALID = 1'b1;
                MASTER_WR_ADDR_ID    = id_q;
                MASTER_WR_ADDR       = addr_q;
                MASTER_WR_ADDR_LEN   = len_q;
                MASTER_WR_ADDR_BURST = BURST_TYPE;
                if (MASTER_WR_ADDR_READY) state_nxt = DATA;
            end
            DATA: begin
                MASTER_WR_DATA       = IN_DATA;
                MASTER_WR_STRB       = IN_STRB;
                MASTER_WR_DATA_VALID = IN_VALID;
                MASTER_WR_DATA_LAST  = last_beat;
                IN_READY             = MASTER_WR_DATA_READY;
                if (w_hs && last_beat) state_nxt = RESP;
            end
            RESP: begin
                MASTER_WR_BACK_READY = 1'b1;
                if (MASTER_WR_BACK_VALID) begin
                    DONE_VALID = 1'b1;
                    DONE_RESP  = (MASTER_WR_BACK_ID == id_q) ? MASTER_WR_BACK_RESP
                                                             : RESP_SLVERR;
                    state_nxt  = IDLE;
                end
`ifdef AXI_WR_TIMEOUT_EN
                else if (tmo_hit) begin
                    DONE_VALID = 1'b1;
                    DONE_RESP  = RESP_DECERR;
                    state_nxt  = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        // Reset is synchronous, so the state register still holds the old
        // state during the reset cycle; gate every output here instead.
        if (!MASTER_RSTN) begin
            CMD_READY            = 1'b0;
            IN_READY             = 1'b0;
            DONE_VALID           = 1'b0;
            DONE_RESP            = '0;
            MASTER_WR_ADDR_ID    = '0;
            MASTER_WR_ADDR       = '0;
            MASTER_WR_ADDR_LEN   = '0;
            MASTER_WR_ADDR_BURST = '0;
            MASTER_WR_ADDR_VALID = 1'b0;
            MASTER_WR_DATA       = '0;
            MASTER_WR_STRB       = '0;
            MASTER_WR_DATA_LAST  = 1'b0;
            MASTER_WR_DATA_VALID = 1'b0;
            MASTER_WR_BACK_READY = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_burst_master
//   Self-checking bench: directed bursts with literal expectations followed
//   by randomized traffic, all compared each cycle against a transaction-
//   level model (busy / address-sent / beats-sent bookkeeping).
//   Define AXI_WR_TIMEOUT_EN to also exercise the B-response timeout.
// ---------------------------------------------------------------------------
module tb_axi_wr_burst_master;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        in_valid, in_ready;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        aw_valid, aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;

    axi_wr_burst_master #(
        .BURST_TYPE  (2'b01),
        .TIMEOUT_CYC (TO)
    ) dut (
        .MASTER_CLK           (clk),
        .MASTER_RSTN          (rstn),
        .CMD_VALID            (cmd_valid),
        .CMD_READY            (cmd_ready),
        .CMD_ADDR             (cmd_addr),
        .CMD_LEN              (cmd_len),
        .CMD_ID               (cmd_id),
        .IN_DATA              (in_data),
        .IN_STRB              (in_strb),
        .IN_VALID             (in_valid),
        .IN_READY             (in_ready),
        .DONE_VALID           (done_valid),
        .DONE_RESP            (done_resp),
        .MASTER_WR_ADDR_ID    (aw_id),
        .MASTER_WR_ADDR       (aw_addr),
        .MASTER_WR_ADDR_LEN   (aw_len),
        .MASTER_WR_ADDR_BURST (aw_burst),
        .MASTER_WR_ADDR_VALID (aw_valid),
        .MASTER_WR_ADDR_READY (aw_ready),
        .MASTER_WR_DATA       (w_data),
        .MASTER_WR_STRB       (w_strb),
        .MASTER_WR_DATA_LAST  (w_last),
        .MASTER_WR_DATA_VALID (w_valid),
        .MASTER_WR_DATA_READY (w_ready),
        .MASTER_WR_BACK_ID    (b_id),
        .MASTER_WR_BACK_RESP  (b_resp),
        .MASTER_WR_BACK_VALID (b_valid),
        .MASTER_WR_BACK_READY (b_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction-level model
    bit          m_busy, m_aw_done;
    int          m_beats, m_len, m_resp_cyc;
    logic [31:0] m_addr;
    logic [3:0]  m_id;

    // Observations of DUT activity, used for the literal expectations
    int          obs_acc_cnt, obs_acc_cyc;
    int          obs_beats, obs_last_cnt, obs_last_idx;
    int          obs_done_cnt, obs_done_cyc, obs_resp_entry;
    int          obs_rst_nonzero;
    logic [1:0]  obs_done_resp;
    logic [31:0] obs_aw_addr;
    logic [7:0]  obs_aw_len;
    logic [3:0]  obs_aw_id;
    logic        obs_cmd_ready, prev_b_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit timeout_hit();
        bit rph;
        rph = m_busy && m_aw_done && (m_beats == m_len + 1);
`ifdef AXI_WR_TIMEOUT_EN
        return rph && (m_resp_cyc == TO);
`else
        return rph && 1'b0;
`endif
    endfunction

    task automatic compare_cycle();
        bit live, awv, dph, rph, dn;
        logic [1:0] exp_resp;
        live = rstn;
        awv  = live && m_busy && !m_aw_done;
        dph  = live && m_busy && m_aw_done && (m_beats <= m_len);
        rph  = live && m_busy && m_aw_done && (m_beats == m_len + 1);
        dn   = rph && (b_valid || timeout_hit());
        if (!dn)          exp_resp = 2'b00;
        else if (b_valid) exp_resp = (b_id == m_id) ? b_resp : 2'b10;
        else              exp_resp = 2'b11;
        check("cmd_ready",  cmd_ready,  live && !m_busy);
        check("aw_valid",   aw_valid,   awv);
        check("aw_addr",    aw_addr,    awv ? m_addr : 32'h0);
        check("aw_len",     aw_len,     awv ? m_len  : 0);
        check("aw_id",      aw_id,      awv ? m_id   : 4'h0);
        check("aw_burst",   aw_burst,   awv ? 2'b01  : 2'b00);
        check("w_valid",    w_valid,    dph && in_valid);
        check("w_data",     w_data,     dph ? in_data : 32'h0);
        check("w_strb",     w_strb,     dph ? in_strb : 4'h0);
        check("w_last",     w_last,     dph && (m_beats == m_len));
        check("in_ready",   in_ready,   dph && w_ready);
        check("b_ready",    b_ready,    rph);
        check("done_valid", done_valid, dn);
        check("done_resp",  done_resp,  exp_resp);
    endtask

    task automatic observe();
        obs_cmd_ready = cmd_ready;
        if (cmd_valid && cmd_ready) begin
            obs_acc_cnt++;
            obs_acc_cyc = cyc;
        end
        if (aw_valid && aw_ready) begin
            obs_aw_addr = aw_addr;
            obs_aw_len  = aw_len;
            obs_aw_id   = aw_id;
        end
        if (w_valid && w_ready) begin
            obs_beats++;
            if (w_last) begin
                obs_last_cnt++;
                obs_last_idx = obs_beats;
            end
        end
        if (b_ready && !prev_b_ready) obs_resp_entry = cyc;
        prev_b_ready = b_ready;
        if (done_valid) begin
            obs_done_cnt++;
            obs_done_cyc  = cyc;
            obs_done_resp = done_resp;
        end
        if (!rstn && (cmd_ready || in_ready || done_valid || done_resp != 0 || aw_id != 0 ||
                      aw_addr != 0 || aw_len != 0 || aw_burst != 0 || aw_valid || w_data != 0 ||
                      w_strb != 0 || w_last || w_valid || b_ready))
            obs_rst_nonzero++;
    endtask

    task automatic model_update();
        if (!rstn) begin
            m_busy = 0; m_aw_done = 0; m_beats = 0; m_resp_cyc = 0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1; m_aw_done = 0; m_beats = 0; m_resp_cyc = 0;
                m_addr = cmd_addr; m_len = int'(cmd_len); m_id = cmd_id;
            end
        end else if (!m_aw_done) begin
            if (aw_ready) m_aw_done = 1;
        end else if (m_beats <= m_len) begin
            if (in_valid && w_ready) m_beats++;
        end else begin
            if (b_valid || timeout_hit()) m_busy = 0;
            else m_resp_cyc++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        compare_cycle();
        observe();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_obs();
        obs_acc_cnt = 0; obs_beats = 0; obs_last_cnt = 0; obs_last_idx = 0;
        obs_done_cnt = 0; obs_rst_nonzero = 0; obs_done_resp = 2'bxx;
        obs_acc_cyc = 0; obs_done_cyc = 0; obs_resp_entry = 0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        clear_obs();
        cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
    endtask

    // wmode: 0 = inputs held, 1 = random W/IN handshakes, 2 = W ready every 4th cycle
    task automatic run_burst(input int max_cyc, input int wmode);
        int n;
        n = 0;
        while (obs_done_cnt == 0 && n < max_cyc) begin
            step();
            n++;
            if (obs_acc_cnt > 0) cmd_valid = 1'b0;
            in_data = $urandom;
            in_strb = 4'($urandom);
            if (wmode == 1) begin
                w_ready  = ($urandom_range(0, 2) != 0);
                in_valid = ($urandom_range(0, 3) != 0);
            end else if (wmode == 2) begin
                w_ready = ((cyc + 1) % 4 == 0);
            end
        end
        check("burst_done_count", obs_done_cnt, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        in_data = 0; in_strb = 0; in_valid = 0; aw_ready = 0; w_ready = 0;
        b_id = 0; b_resp = 0; b_valid = 0; prev_b_ready = 0;
        m_busy = 0; m_aw_done = 0; m_beats = 0; m_len = 0; m_resp_cyc = 0;
        m_addr = 0; m_id = 0;
        clear_obs();

        // Reset: everything low, even with requests pending
        cmd_valid = 1'b1; in_valid = 1'b1; b_valid = 1'b1;
        step(); step();
        check("reset_outputs_zero", obs_rst_nonzero, 0);
        check("reset_cmd_ready", obs_cmd_ready, 0);
        cmd_valid = 1'b0; in_valid = 1'b0; b_valid = 1'b0;
        rstn = 1'b1;
        step();
        check("cmd_ready_first_cycle", obs_cmd_ready, 1);

        // 4-beat burst, all readies high
        aw_ready = 1; w_ready = 1; in_valid = 1; b_valid = 1; b_id = 4'd5; b_resp = 2'b00;
        issue(32'h10, 8'd3, 4'd5);
        run_burst(60, 0);
        check("t1_aw_addr", obs_aw_addr, 32'h10);
        check("t1_aw_len", obs_aw_len, 3);
        check("t1_aw_id", obs_aw_id, 5);
        check("t1_beats", obs_beats, 4);
        check("t1_last_count", obs_last_cnt, 1);
        check("t1_last_index", obs_last_idx, 4);
        check("t1_done_resp", obs_done_resp, 2'b00);
        check("t1_latency", obs_done_cyc - obs_acc_cyc, 6);
        idle(2);

        // Single beat, W ready only every 4th cycle
        b_id = 4'd2;
        w_ready = 1'b0;
        issue(32'h2000, 8'd0, 4'd2);
        run_burst(60, 2);
        check("t2_beats", obs_beats, 1);
        check("t2_last_count", obs_last_cnt, 1);
        check("t2_last_index", obs_last_idx, 1);
        idle(3);
        check("t2_single_done", obs_done_cnt, 1);

        // B ID mismatch reports SLVERR
        w_ready = 1; b_id = 4'd3; b_resp = 2'b00;
        issue(32'h44, 8'd0, 4'd5);
        run_burst(60, 0);
        check("t3_id_mismatch_resp", obs_done_resp, 2'b10);
        idle(2);

        // Reset after 2 of 8 beats
        b_valid = 0; b_id = 4'd1;
        issue(32'h300, 8'd7, 4'd1);
        for (int n = 0; n < 30 && obs_beats < 2; n++) begin
            step();
            if (obs_acc_cnt > 0) cmd_valid = 1'b0;
        end
        check("t4_beats_before_reset", obs_beats, 2);
        rstn = 1'b0;
        step();
        check("t4_outputs_zero_in_reset", obs_rst_nonzero, 0);
        rstn = 1'b1; in_valid = 0; b_valid = 1;
        step();
        check("t4_cmd_ready_after_reset", obs_cmd_ready, 1);
        idle(8);
        check("t4_no_done", obs_done_cnt, 0);
        check("t4_no_more_beats", obs_beats, 2);

        // 256-beat burst against a randomly stalling slave
        b_valid = 1; b_id = 4'd9; b_resp = 2'b00; in_valid = 1;
        issue(32'h8000, 8'd255, 4'd9);
        run_burst(3000, 1);
        check("t5_beats", obs_beats, 256);
        check("t5_last_count", obs_last_cnt, 1);
        check("t5_last_index", obs_last_idx, 256);
        check("t5_done_resp", obs_done_resp, 2'b00);
        w_ready = 1; in_valid = 1;
        idle(2);

`ifdef AXI_WR_TIMEOUT_EN
        // B never arrives: timeout after 16 RESP cycles
        b_valid = 0;
        issue(32'h50, 8'd0, 4'd7);
        run_burst(80, 0);
        check("t6_timeout_resp", obs_done_resp, 2'b11);
        check("t6_timeout_latency", obs_done_cyc - obs_resp_entry, 16);
        idle(2);
`endif

        // Randomized traffic with occasional resets
        clear_obs();
        for (int i = 0; i < 4000; i++) begin
            rstn      = ($urandom_range(0, 199) != 0);
            cmd_valid = ($urandom_range(0, 1) != 0);
            cmd_addr  = $urandom;
            cmd_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                    : 8'($urandom_range(0, 3));
            cmd_id    = 4'($urandom);
            in_data   = $urandom;
            in_strb   = 4'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            aw_ready  = ($urandom_range(0, 9) < 6);
            w_ready   = ($urandom_range(0, 9) < 7);
            b_valid   = ($urandom_range(0, 9) < 3);
            b_id      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : m_id;
            b_resp    = 2'($urandom);
            step();
        end
        check("random_done_seen", obs_done_cnt > 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_master.md
AXI_WR_BURST_MASTER -- requirements
Module: axi_wr_burst_master

Interface
REQ-001 SHALL have parameter BURST_TYPE, default 2'b01, value driven on MASTER_WR_ADDR_BURST.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, write-response wait limit in cycles (used only with AXI_WR_TIMEOUT_EN).
REQ-003 SHALL use one clock and a synchronous, active-low reset; no other clock or reset.
REQ-004 SHALL have ports, one per line:
  MASTER_CLK  in  1  sole clock, all logic on rising edge
  MASTER_RSTN  in  1  synchronous active-low reset
  CMD_VALID  in  1  burst command valid
  CMD_READY  out  1  command accepted when both high
  CMD_ADDR  in  32  start word address
  CMD_LEN  in  8  beats minus one
  CMD_ID  in  4  transaction ID
  IN_DATA  in  32  write beat data
  IN_STRB  in  4  write beat byte strobes
  IN_VALID  in  1  beat valid
  IN_READY  out  1  beat consumed when both high
  DONE_VALID  out  1  one-cycle completion pulse
  DONE_RESP  out  2  completion response
  MASTER_WR_ADDR_ID  out  4  AW ID
  MASTER_WR_ADDR  out  32  AW address
  MASTER_WR_ADDR_LEN  out  8  AW length
  MASTER_WR_ADDR_BURST  out  2  AW burst type
  MASTER_WR_ADDR_VALID  out  1  AW valid
  MASTER_WR_ADDR_READY  in  1  AW ready
  MASTER_WR_DATA  out  32  W data
  MASTER_WR_STRB  out  4  W strobes
  MASTER_WR_DATA_LAST  out  1  W last
  MASTER_WR_DATA_VALID  out  1  W valid
  MASTER_WR_DATA_READY  in  1  W ready
  MASTER_WR_BACK_ID  in  4  B ID
  MASTER_WR_BACK_RESP  in  2  B response
  MASTER_WR_BACK_VALID  in  1  B valid
  MASTER_WR_BACK_READY  out  1  B ready

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one burst in flight at a time.
REQ-006 SHALL drive CMD_READY=1 only in IDLE; on CMD_VALID&&CMD_READY, register addr/len/id and go to ADDR on the next cycle.
REQ-007 SHALL hold MASTER_WR_ADDR_VALID=1 with stable AW fields throughout ADDR; on AW handshake go to DATA.
REQ-008 SHALL in DATA combinationally pass IN_DATA/IN_STRB/IN_VALID to W and MASTER_WR_DATA_READY to IN_READY; both forced 0 outside DATA.
REQ-009 SHALL count accepted W beats with a 9-bit counter from 0; MASTER_WR_DATA_LAST=1 when count==registered len (len=0 gives LAST on first beat; len=255 gives 256 beats).
REQ-010 SHALL on the LAST handshake go to RESP; a beat after LAST is never accepted.
REQ-011 SHALL drive MASTER_WR_BACK_READY=1 only in RESP; on B handshake pulse DONE_VALID for one cycle and return to IDLE.
REQ-012 SHALL set DONE_RESP=MASTER_WR_BACK_RESP when BACK_ID equals registered ID, else 2'b10 (SLVERR).
REQ-013 SHALL ignore MASTER_WR_BACK_VALID outside RESP.
REQ-014 SHALL accept a new command in the cycle after DONE_VALID at the earliest (minimum 4 cycles per 1-beat burst with all readies high).

Reset
REQ-015 SHALL while MASTER_RSTN=0 force state IDLE, beat counter 0, every output 0 (including CMD_READY); DONE_VALID is not issued for a burst dropped by reset.
REQ-016 SHALL show CMD_READY=1 in the first cycle after MASTER_RSTN rises.

Configuration
REQ-017 SHALL, with macro AXI_WR_TIMEOUT_EN defined, count cycles in RESP and, on reaching TIMEOUT_CYC without B handshake, pulse DONE_VALID with DONE_RESP=2'b11 and return to IDLE.
REQ-018 SHALL, without AXI_WR_TIMEOUT_EN, contain no timeout counter and wait in RESP indefinitely.

Structure
REQ-019 SHALL place the state enum, burst codes (FIXED/INCR/WRAP) and response codes (OKAY/EXOKAY/SLVERR/DECERR) in shared package axi_pkg.
REQ-020 SHALL be a single module with no sub-modules.

Verification
REQ-021 cmd addr=0x10 len=3 id=5, all readies high, IN_VALID constant -> AW addr 0x10 len 3 ID 5, 4 beats, LAST on 4th, DONE_VALID resp 2'b00.
REQ-022 len=0 with MASTER_WR_DATA_READY high every 4th cycle -> one beat with LAST=1, IN_READY mirrors W ready, single DONE_VALID.
REQ-023 B response with ID 3 for a burst issued with ID 5 -> DONE_RESP=2'b10.
REQ-024 MASTER_RSTN low for 1 cycle mid-DATA after 2 of 8 beats -> all outputs 0 next cycle, no DONE_VALID, CMD_READY=1 after release.
REQ-025 AXI_WR_TIMEOUT_EN defined, TIMEOUT_CYC=16, B valid withheld -> DONE_VALID with resp 2'b11 16 cycles after entering RESP.
REQ-026 len=255 against the slave simulation model -> 256 beats written, LAST only on beat 256, resp 2'b00.
